// File: rtl/warp_gto_select_pkg.sv
// Shared scheduling types and defaults for the warp selector.
// Holds the policy encoding and the default greedy budget.
package warp_gto_select_pkg;

  typedef enum logic {
    SCHED_LRR = 1'b0,
    SCHED_GTO = 1'b1
  } sched_policy_t;

  localparam int GTO_GREEDY_MAX_DEFAULT = 8;

  // Width of an index into n items; never below one bit.
  function automatic int clog2_up(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/warp_gto_select_age_argmax.sv
// Combinational oldest-warp finder: maximum age among masked warps,
// ties resolved towards the lowest warp id.
module warp_age_argmax #(
  parameter int WARP_CNT       = 4,
  parameter int WARP_CNT_WIDTH = 2,
  parameter int AGE_WIDTH      = 6
) (
  input  logic [WARP_CNT-1:0]           mask,
  input  logic [WARP_CNT*AGE_WIDTH-1:0] ages,
  output logic                          valid,
  output logic [WARP_CNT_WIDTH-1:0]     wid
);

  logic [AGE_WIDTH-1:0] best_age;

  // Strict greater-than keeps the earlier (lower) wid on equal ages.
  always_comb begin
    valid    = 1'b0;
    wid      = '0;
    best_age = '0;
    for (int w = 0; w < WARP_CNT; w++) begin
      if (mask[w] && (!valid || (ages[w*AGE_WIDTH +: AGE_WIDTH] > best_age))) begin
        valid    = 1'b1;
        wid      = WARP_CNT_WIDTH'(w);
        best_age = ages[w*AGE_WIDTH +: AGE_WIDTH];
      end
    end
  end

endmodule

// File: rtl/warp_gto_select.sv
// Policy-driven warp selector (loose round-robin or greedy-then-oldest)
// with per-warp wait ages, a starvation alert and a switch counter.
module warp_gto_select
  import warp_gto_select_pkg::*;
#(
  parameter int WARP_CNT       = 4,
  parameter int WARP_CNT_WIDTH = clog2_up(WARP_CNT),
  parameter int GREEDY_MAX     = GTO_GREEDY_MAX_DEFAULT,
  parameter int AGE_WIDTH      = 6,
  parameter int CTR_WIDTH      = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      policy,
  input  logic [WARP_CNT-1:0]       ready_warps,
  input  logic [WARP_CNT-1:0]       spawn_mask,
  output logic                      sel_valid,
  output logic [WARP_CNT_WIDTH-1:0] sel_wid,
  input  logic                      sel_ready,
  output logic                      starve_alert,
  output logic [CTR_WIDTH-1:0]      switch_count
);

  localparam int CNT_W = $clog2(GREEDY_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(GREEDY_MAX - 1);
  localparam logic [AGE_WIDTH-1:0] AGE_SAT = {AGE_WIDTH{1'b1}};
  localparam logic [WARP_CNT_WIDTH-1:0] WID_LAST = WARP_CNT_WIDTH'(WARP_CNT - 1);

  logic [WARP_CNT_WIDTH-1:0] rr_ptr;
  logic [WARP_CNT_WIDTH-1:0] greedy_wid;
  logic                      greedy_vld;
  logic [CNT_W-1:0]          greedy_cnt;
  logic [AGE_WIDTH-1:0]      age [WARP_CNT];
  logic [WARP_CNT_WIDTH-1:0] last_wid;

  logic [WARP_CNT*AGE_WIDTH-1:0] age_flat;
  logic [WARP_CNT-1:0]           greedy_onehot;
  logic                          old_all_valid, old_oth_valid;
  logic [WARP_CNT_WIDTH-1:0]     old_all_wid, old_oth_wid;
  logic                          lrr_found;
  logic [WARP_CNT_WIDTH-1:0]     lrr_wid;
  logic                          budget_left, greedy_pick, forced_switch;
  logic [WARP_CNT_WIDTH-1:0]     gto_wid;
  logic                          fire;

  always_comb begin
    age_flat = '0;
    for (int w = 0; w < WARP_CNT; w++) begin
      age_flat[w*AGE_WIDTH +: AGE_WIDTH] = age[w];
    end
  end

  assign greedy_onehot = WARP_CNT'(1) << greedy_wid;

  warp_age_argmax #(
    .WARP_CNT      (WARP_CNT),
    .WARP_CNT_WIDTH(WARP_CNT_WIDTH),
    .AGE_WIDTH     (AGE_WIDTH)
  ) u_oldest_all (
    .mask (ready_warps),
    .ages (age_flat),
    .valid(old_all_valid),
    .wid  (old_all_wid)
  );

  warp_age_argmax #(
    .WARP_CNT      (WARP_CNT),
    .WARP_CNT_WIDTH(WARP_CNT_WIDTH),
    .AGE_WIDTH     (AGE_WIDTH)
  ) u_oldest_other (
    .mask (ready_warps & ~greedy_onehot),
    .ages (age_flat),
    .valid(old_oth_valid),
    .wid  (old_oth_wid)
  );

  // Loose round-robin: first ready warp at or after rr_ptr, wrapping.
  always_comb begin
    logic [WARP_CNT_WIDTH:0] idx;
    lrr_found = 1'b0;
    lrr_wid   = '0;
    idx       = '0;
    for (int i = 0; i < WARP_CNT; i++) begin
      idx = {1'b0, rr_ptr} + (WARP_CNT_WIDTH + 1)'(i);
      if (idx >= (WARP_CNT_WIDTH + 1)'(WARP_CNT)) begin
        idx = idx - (WARP_CNT_WIDTH + 1)'(WARP_CNT);
      end
      if (!lrr_found && ready_warps[idx[WARP_CNT_WIDTH-1:0]]) begin
        lrr_found = 1'b1;
        lrr_wid   = idx[WARP_CNT_WIDTH-1:0];
      end
    end
  end

  assign budget_left   = greedy_cnt < CNT_LAST;
  assign greedy_pick   = greedy_vld && ready_warps[greedy_wid] && budget_left;
  assign forced_switch = greedy_vld && !budget_left && (old_all_wid == greedy_wid) && old_oth_valid;
  assign gto_wid       = greedy_pick ? greedy_wid : (forced_switch ? old_oth_wid : old_all_wid);

  // Handshake: the offer (sel_valid, sel_wid) is combinational and may change
  // freely while sel_ready is low; a transfer happens only when both are high.
  assign sel_valid = |ready_warps;
  assign sel_wid   = !sel_valid ? '0 :
                     (sched_policy_t'(policy) == SCHED_GTO) ? gto_wid : lrr_wid;
  assign fire      = sel_valid && sel_ready;

  always_comb begin
    starve_alert = 1'b0;
    for (int w = 0; w < WARP_CNT; w++) begin
      starve_alert = starve_alert | (ready_warps[w] && (age[w] == AGE_SAT));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr       <= '0;
      greedy_wid   <= '0;
      greedy_vld   <= 1'b0;
      greedy_cnt   <= '0;
      last_wid     <= '0;
      switch_count <= '0;
      for (int w = 0; w < WARP_CNT; w++) begin
        age[w] <= '0;
      end
    end else begin
      for (int w = 0; w < WARP_CNT; w++) begin
        if (spawn_mask[w]) begin
          age[w] <= '0;
        end else if (fire && (sel_wid == WARP_CNT_WIDTH'(w))) begin
          age[w] <= '0;
        end else if (ready_warps[w] && (age[w] != AGE_SAT)) begin
          age[w] <= age[w] + 1'b1;
        end
      end
      if (fire) begin
        rr_ptr   <= (sel_wid == WID_LAST) ? '0 : sel_wid + 1'b1;
        last_wid <= sel_wid;
        if (sel_wid != last_wid) begin
          switch_count <= switch_count + 1'b1;
        end
        // Greedy state tracks both policies so a policy change is seamless;
        // the count saturates since only "below the budget" matters.
        if (greedy_vld && (sel_wid == greedy_wid)) begin
          if (greedy_cnt != CNT_LAST) begin
            greedy_cnt <= greedy_cnt + 1'b1;
          end
        end else begin
          greedy_wid <= sel_wid;
          greedy_vld <= 1'b1;
          greedy_cnt <= '0;
        end
      end
    end
  end

endmodule
